// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// result codes and default timing in 50 MHz clock cycles.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_RELEASE
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_START_CYCLES   = 20;
  localparam int unsigned DEF_START_TIMEOUT  = 750000;
  localparam int unsigned DEF_PACKET_TIMEOUT = 100000;

endpackage

// File: rtl/ps2_transmit_if.sv
// Host-side command handshake of the PS/2 transmitter.
interface ps2_transmit_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic [1:0] err;

  modport master (output tx_data, output tx_start, input busy, input done, input err);
  modport slave  (input tx_data, input tx_start, output busy, output done, output err);
endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 pin plus a falling-edge detector on the
// synchronized level. All flops idle high, matching a released bus line.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pin_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_transmit.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues request-to-
// send, shifts the byte on device clock edges and reports ack / no-ack / timeout.
module ps2_transmit
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_CYCLES   = DEF_START_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          ps2_clk_i,
  input  logic          ps2_dat_i,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe,
  ps2_transmit_if.slave host
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] STO_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PTO_LAST = CNT_W'(PACKET_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_sync u_clk_sync (
    .clk     (clock),
    .rst_n   (resetn),
    .pin_i   (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_sync u_dat_sync (
    .clk     (clock),
    .rst_n   (resetn),
    .pin_i   (ps2_dat_i),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (host.tx_start) begin
          data_d   = host.tx_data;
          par_d    = ~^host.tx_data;
          idx_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q >= STR_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          idx_d    = '0;
          state_d  = S_BITS;
        end
      end
      S_BITS: begin
        if (clk_fall) begin
          // idx_q counts edges already seen; the packet timer restarts on edge 1
          idx_d = idx_q + 1'b1;
          if (idx_q == 4'd0) cnt_d = '0;
          if (idx_q <= 4'd7)       dat_oe_d = ~data_q[idx_q[2:0]];
          else if (idx_q == 4'd8)  dat_oe_d = ~par_q;
          else if (idx_q == 4'd9)  dat_oe_d = 1'b0;
          else begin
            err_d   = dat_lvl ? ERR_NOACK : ERR_OK;
            state_d = S_RELEASE;
          end
        end else if ((idx_q == 4'd0 && cnt_q >= STO_LAST) ||
                     (idx_q != 4'd0 && cnt_q >= PTO_LAST)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          err_d    = ERR_TIMEOUT;
          state_d  = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (clk_lvl && dat_lvl) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b1;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign host.busy  = (state_q != S_IDLE);
  assign host.done  = done_q;
  assign host.err   = err_q;

endmodule

// File: tb/tb_ps2_transmit.sv
// Bench for ps2_transmit: a behavioural PS/2 device clocks the frame out and
// acks (or not), results are compared against frames built from the byte.
module tb_ps2_transmit;

  localparam int INH = 60;
  localparam int STC = 10;
  localparam int STO = 300;
  localparam int PTO = 1500;
  localparam int H   = 20;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic clk_oe, dat_oe;
  logic ps2_clk_i, ps2_dat_i;

  // open-collector bus: low if either side pulls it low
  assign ps2_clk_i = dev_clk & ~clk_oe;
  assign ps2_dat_i = dev_dat & ~dat_oe;

  ps2_transmit_if host ();

  ps2_transmit #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .START_TIMEOUT  (STO),
    .PACKET_TIMEOUT (PTO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe),
    .host       (host)
  );

  always #5 clock = ~clock;

  int vectors  = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit spam_on  = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (host.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [7:0] d);
    host.tx_data  = d;
    host.tx_start = 1'b1;
    tick(1);
    host.tx_start = 1'b0;
  endtask

  task automatic phases();
    int n;
    chk("clk_inhibit", clk_oe, 1);
    n = 0;
    while (dat_oe !== 1'b1 && n < INH + 10) begin tick(1); n++; end
    chk("inhibit_len", n, INH);
    n = 0;
    while (clk_oe !== 1'b0 && n < STC + 10) begin tick(1); n++; end
    chk("start_len", n, STC);
  endtask

  // Device clocks n falling edges; samples DAT while CLK is high after each edge.
  task automatic dev_edges(input int n, input bit ack, output logic [9:0] got, output int f1);
    got = '0;
    f1  = 0;
    for (int k = 1; k <= n; k++) begin
      dev_clk = 1'b0;
      if (k == 1) f1 = cyc;
      tick(H);
      if (k == 11) spam_on = 1'b0;
      dev_clk = 1'b1;
      if (k <= 10) got[k-1] = ps2_dat_i;
      if (k == 10 && ack) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      else tick(H);
    end
  endtask

  task automatic xfer_body(input logic [7:0] d, input bit ack, input bit restart, input logic [7:0] d2);
    logic [9:0] got, exp;
    int f1, n, ones;
    logic p;
    phases();
    tick(10);
    dev_edges(11, ack, got, f1);
    ones = $countones(d);
    p = (ones % 2 == 0);
    exp = {1'b1, p, d};
    chk("frame", got, exp);
    n = 0;
    while (host.done !== 1'b1 && n < 20) begin tick(1); n++; end
    chk("done_seen", host.done, 1);
    chk("err", host.err, ack ? 0 : 1);
    chk("oe_at_done", {clk_oe, dat_oe}, 0);
    chk("busy_at_done", host.busy, 0);
    if (restart) begin
      host.tx_data  = d2;
      host.tx_start = 1'b1;
    end
    tick(1);
    host.tx_start = 1'b0;
    chk("done_pulse", host.done, 0);
    chk("err_hold", host.err, ack ? 0 : 1);
    if (restart) chk("restart_busy", host.busy, 1);
  endtask

  initial begin
    logic [7:0] d, d1, d2;
    logic [9:0] got;
    int n, f1, dc0, el;

    host.tx_start = 1'b0;
    host.tx_data  = '0;
    tick(3);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_busy", host.busy, 0);
    chk("rst_done", host.done, 0);
    chk("rst_err", host.err, 0);
    resetn = 1'b1;
    tick(3);

    issue(8'hED); xfer_body(8'hED, 1'b1, 1'b0, 8'h00);
    issue(8'h01); xfer_body(8'h01, 1'b1, 1'b0, 8'h00);
    issue(8'h00); xfer_body(8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      tick(5);
      issue(d); xfer_body(d, 1'b1, 1'b0, 8'h00);
    end

    // no ack; err must persist afterwards
    d = 8'($urandom);
    issue(d); xfer_body(d, 1'b0, 1'b0, 8'h00);
    tick(50);
    chk("err_hold_long", host.err, 1);

    // device never clocks
    issue(8'($urandom));
    phases();
    n = 0;
    while (host.done !== 1'b1 && n < STO + 20) begin tick(1); n++; end
    chk("start_timeout_len", n, STO);
    chk("start_timeout_err", host.err, 2);
    chk("start_timeout_oe", {clk_oe, dat_oe}, 0);
    tick(5);

    // device stops after three edges
    issue(8'($urandom));
    phases();
    tick(10);
    dev_edges(3, 1'b1, got, f1);
    n = 0;
    while (host.done !== 1'b1 && n < PTO + 200) begin tick(1); n++; end
    el = cyc - f1;
    chk("pkt_timeout_window", (el >= PTO && el <= PTO + 4), 1);
    chk("pkt_timeout_err", host.err, 2);
    chk("pkt_timeout_oe", {clk_oe, dat_oe}, 0);
    tick(5);

    // reset after edge 4 with data bit 3 = 0 so DAT is being pulled
    d = 8'($urandom) & 8'hF7;
    issue(d);
    phases();
    tick(10);
    dev_edges(4, 1'b1, got, f1);
    chk("pre_reset_dat_oe", dat_oe, 1);
    dc0 = done_cnt;
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_oe", {clk_oe, dat_oe}, 0);
    chk("mid_rst_busy", host.busy, 0);
    tick(5);
    resetn = 1'b1;
    tick(5);
    chk("mid_rst_no_done", done_cnt - dc0, 0);
    d = 8'($urandom);
    issue(d); xfer_body(d, 1'b1, 1'b0, 8'h00);
    tick(5);

    // repeated tx_start during a transfer, then back-to-back on the done cycle
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    dc0 = done_cnt;
    spam_on = 1'b1;
    issue(d1);
    fork
      xfer_body(d1, 1'b1, 1'b1, d2);
      begin
        int c = 0;
        while (spam_on) begin
          tick(1);
          c++;
          if (c % 100 == 0 && spam_on && host.busy === 1'b1 && host.done !== 1'b1) begin
            host.tx_data  = 8'($urandom);
            host.tx_start = 1'b1;
            tick(1);
            host.tx_start = 1'b0;
          end
        end
      end
    join
    chk("spam_single_done", done_cnt - dc0, 1);
    xfer_body(d2, 1'b1, 1'b0, 8'h00);
    chk("second_done", done_cnt - dc0, 2);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_transmit.md
PS2_TRANSMIT -- requirements
Module: ps2_transmit

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000; clock cycles CLK is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter START_CYCLES, default 20; cycles DAT is held low before CLK is released.
REQ-003 SHALL have parameter START_TIMEOUT, default 750000; maximum cycles from CLK release to the first device falling edge (15 ms).
REQ-004 SHALL have parameter PACKET_TIMEOUT, default 100000; maximum cycles from the first falling edge to the ack edge (2 ms).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clock  input  1  system clock (clock_50 domain), rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 ps2_clk_i  input  1  raw PS2_CLK pin level, asynchronous.
REQ-009 ps2_dat_i  input  1  raw PS2_DAT pin level, asynchronous.
REQ-010 ps2_clk_oe  output  1  1 = top level drives PS2_CLK low; 0 = Z.
REQ-011 ps2_dat_oe  output  1  1 = top level drives PS2_DAT low; 0 = Z.
REQ-012 tx_data  input  8  command byte; captured when tx_start is accepted.
REQ-013 tx_start  input  1  single-cycle request; accepted only in IDLE.
REQ-014 busy  output  1  high in every state except IDLE; the receiver's data-valid strobe is gated with it.
REQ-015 done  output  1  one-cycle pulse when a transfer ends, for any reason.
REQ-016 err  output  2  result, valid while done=1: 00 ack ok, 01 no ack, 10 timeout.

Function
REQ-017 PS/2 inputs SHALL pass through 2-flop synchronizers; a falling edge SHALL be registered when the synchronized CLK goes 1 -> 0.
REQ-018 State machine states SHALL be IDLE, INHIBIT, START, BITS, RELEASE.
REQ-019 IDLE + tx_start: latch tx_data, compute odd parity (~^tx_data), clear counters, set ps2_clk_oe=1, go to INHIBIT.
REQ-020 INHIBIT: after INHIBIT_CYCLES cycles set ps2_dat_oe=1, go to START.
REQ-021 START: after START_CYCLES cycles set ps2_clk_oe=0, bit index = 0, go to BITS.
REQ-022 BITS, on falling edge k (1-based): k=1..8 set ps2_dat_oe = ~data[k-1] (LSB first); k=9 set ps2_dat_oe = ~parity; k=10 set ps2_dat_oe=0 (stop bit); k=11 sample DAT: 0 -> err=00, 1 -> err=01, then go to RELEASE.
REQ-023 RELEASE: wait until synchronized CLK=1 and DAT=1, then go to IDLE with done=1 for one cycle.
REQ-024 Timeout SHALL apply in BITS when no falling edge occurs within START_TIMEOUT cycles of CLK release, or edge 11 is not seen within PACKET_TIMEOUT cycles of edge 1: set both oe=0, done=1, err=10, go to IDLE directly.
REQ-025 The timeout/delay counter SHALL be 20 bits wide and saturate rather than wrap.
REQ-026 tx_start while busy=1 SHALL be ignored with no side effect.
REQ-027 done SHALL coincide with the first IDLE cycle; a tx_start in that cycle SHALL be accepted.
REQ-028 err SHALL hold its value until the next done.
REQ-029 A falling edge seen in IDLE, INHIBIT or START (the device talking) SHALL be ignored.

Reset
REQ-030 On resetn=0, state=IDLE immediately; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=00, all counters and synchronizers = 1/idle.
REQ-031 Reset mid-transfer SHALL release both lines in the same cycle, with no done pulse.

Structure
REQ-032 Package ps2_pkg SHALL hold the state encoding, the err code constants and the default timing constants.
REQ-033 Sub-module ps2_sync SHALL hold the 2-flop synchronizer plus falling-edge detector; it is instantiated for CLK (with edge output) and DAT.
REQ-034 Top-level wiring SHALL be PS2_CLK = ps2_clk_oe ? 0 : Z, and PS2_DAT likewise; no tri-state logic inside the block.

Verification
REQ-035 tx_data=0xED; device model clocks at 10 kHz and acks -> CLK low 5000 cycles; DAT bits 1,0,1,1,0,1,1,1; parity 1; stop 1; done with err=00.
REQ-036 tx_data=0x01 -> parity bit 0 on edge 9; 0x00 -> parity bit 1.
REQ-037 Device leaves DAT high at edge 11 -> done, err=01, both oe=0.
REQ-038 Device never clocks -> done exactly START_TIMEOUT cycles after CLK release, err=10, both lines released.
REQ-039 resetn pulsed low after edge 4 -> both oe=0 asynchronously, busy=0, no done; a following tx_start runs normally.
REQ-040 tx_start repeated every 100 cycles during a transfer -> exactly one transfer, a single done; tx_start on the done cycle starts a second transfer.
